// File: rtl/adc_sample_averager.sv
// -----------------------------------------------------------------------------
// adc_sample_averager
//
// Boxcar averager for tagged ADC conversion results. Each channel keeps its own
// accumulator and sample counter. When a channel has collected 2^LOG2_AVG
// samples, the truncated mean is presented for one cycle on out_valid, and that
// channel's window restarts.
//
// Parameters:
//   SAMPLE_WIDTH  width of the unsigned ADC samples
//   NUM_CHANNELS  number of independent channels (2..16)
//   LOG2_AVG      log2 of the window length (0..8)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous clear of all per-channel state; beats in_valid
//   in_valid     one-cycle sample strobe
//   in_channel   channel tag of in_sample
//   in_sample    unsigned ADC result
//   out_valid    one-cycle pulse, averaged result available
//   out_channel  channel of the current result (held between pulses)
//   out_average  window mean, truncated (held between pulses)
//   drop_pulse   one-cycle pulse, sample rejected because of a bad channel tag
//   out_min      window minimum (peak-hold build only, otherwise 0)
//   out_max      window maximum (peak-hold build only, otherwise 0)
//
// Build option:
//   ADC_AVG_PEAK_HOLD_EN  when defined, per-channel running min/max are kept and
//                         reported with each average; when undefined, out_min
//                         and out_max are tied to 0 and no min/max state exists.
// -----------------------------------------------------------------------------
module adc_sample_averager #(
  parameter  int SAMPLE_WIDTH = 10,
  parameter  int NUM_CHANNELS = 8,
  parameter  int LOG2_AVG     = 4,
  localparam int CH_WIDTH     = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [CH_WIDTH-1:0]     in_channel,
  input  logic [SAMPLE_WIDTH-1:0] in_sample,
  output logic                    out_valid,
  output logic [CH_WIDTH-1:0]     out_channel,
  output logic [SAMPLE_WIDTH-1:0] out_average,
  output logic                    drop_pulse,
  output logic [SAMPLE_WIDTH-1:0] out_min,
  output logic [SAMPLE_WIDTH-1:0] out_max
);

  // Sum of a full window of SAMPLE_WIDTH-bit samples fits in ACC_W bits.
  localparam int ACC_W = SAMPLE_WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  // Truncating mean of a completed window.
  function automatic logic [SAMPLE_WIDTH-1:0] trunc_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] shifted;
    shifted = sum >> LOG2_AVG;
    return shifted[SAMPLE_WIDTH-1:0];
  endfunction

  // Per-channel window state.
  logic [ACC_W-1:0] r_acc [NUM_CHANNELS];
  logic [CNT_W-1:0] r_cnt [NUM_CHANNELS];

  // Output stage.
  logic                    r_out_vld_p1;
  logic                    r_drop_vld_p1;
  logic [CH_WIDTH-1:0]     r_out_ch_p1;
  logic [SAMPLE_WIDTH-1:0] r_out_avg_p1;

  logic             w_ch_ok;
  logic             w_accept;
  logic             w_done;
  logic [ACC_W-1:0] w_acc_sel;
  logic [CNT_W-1:0] w_cnt_sel;
  logic [ACC_W-1:0] w_sum;

  // A tag can only be out of range when NUM_CHANNELS is not a power of two;
  // the widened compare keeps the power-of-two case free of a constant test.
  generate
    if (NUM_CHANNELS == (1 << CH_WIDTH)) begin : g_tag_full
      assign w_ch_ok = 1'b1;
    end else begin : g_tag_range
      assign w_ch_ok = ({1'b0, in_channel} < (CH_WIDTH + 1)'(NUM_CHANNELS));
    end
  endgenerate

  // Select the addressed channel's state by compare rather than by indexing,
  // so a bad tag never reads past the end of the arrays.
  always_comb begin
    w_acc_sel = '0;
    w_cnt_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_channel == CH_WIDTH'(c)) begin
        w_acc_sel = r_acc[c];
        w_cnt_sel = r_cnt[c];
      end
    end
  end

  // clear wins over a coincident sample: nothing is accepted or dropped.
  assign w_accept = in_valid && !clear && w_ch_ok;
  assign w_done   = w_accept && (w_cnt_sel == CNT_LAST);
  assign w_sum    = w_acc_sel + ACC_W'(in_sample);

  // ---- stage p0 -> p1: accumulate, detect window completion ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_cnt[c] <= '0;
      end
      r_out_vld_p1  <= 1'b0;
      r_drop_vld_p1 <= 1'b0;
      r_out_ch_p1   <= '0;
      r_out_avg_p1  <= '0;
    end else begin
      r_out_vld_p1  <= w_done;
      r_drop_vld_p1 <= in_valid && !clear && !w_ch_ok;

      // Result registers only move on completion so they hold between pulses.
      if (w_done) begin
        r_out_ch_p1  <= in_channel;
        r_out_avg_p1 <= trunc_avg(w_sum);
      end

      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (clear) begin
          r_acc[c] <= '0;
          r_cnt[c] <= '0;
        end else if (w_accept && (in_channel == CH_WIDTH'(c))) begin
          if (w_done) begin
            r_acc[c] <= '0;
            r_cnt[c] <= '0;
          end else begin
            r_acc[c] <= w_sum;
            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign out_valid   = r_out_vld_p1;
  assign drop_pulse  = r_drop_vld_p1;
  assign out_channel = r_out_ch_p1;
  assign out_average = r_out_avg_p1;

`ifdef ADC_AVG_PEAK_HOLD_EN

  localparam logic [SAMPLE_WIDTH-1:0] MIN_INIT = '1;

  function automatic logic [SAMPLE_WIDTH-1:0] pick_min(input logic [SAMPLE_WIDTH-1:0] a,
                                                       input logic [SAMPLE_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [SAMPLE_WIDTH-1:0] pick_max(input logic [SAMPLE_WIDTH-1:0] a,
                                                       input logic [SAMPLE_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [SAMPLE_WIDTH-1:0] r_min [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] r_max [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] r_out_min_p1;
  logic [SAMPLE_WIDTH-1:0] r_out_max_p1;

  logic [SAMPLE_WIDTH-1:0] w_min_sel;
  logic [SAMPLE_WIDTH-1:0] w_max_sel;
  logic [SAMPLE_WIDTH-1:0] w_min_new;
  logic [SAMPLE_WIDTH-1:0] w_max_new;

  always_comb begin
    w_min_sel = MIN_INIT;
    w_max_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_channel == CH_WIDTH'(c)) begin
        w_min_sel = r_min[c];
        w_max_sel = r_max[c];
      end
    end
  end

  // Extremes include the sample being accepted, so the completing sample counts.
  assign w_min_new = pick_min(w_min_sel, in_sample);
  assign w_max_new = pick_max(w_max_sel, in_sample);

  // ---- stage p0 -> p1: running extremes, aligned with the average ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_min[c] <= MIN_INIT;
        r_max[c] <= '0;
      end
      r_out_min_p1 <= '0;
      r_out_max_p1 <= '0;
    end else begin
      if (w_done) begin
        r_out_min_p1 <= w_min_new;
        r_out_max_p1 <= w_max_new;
      end

      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (clear) begin
          r_min[c] <= MIN_INIT;
          r_max[c] <= '0;
        end else if (w_accept && (in_channel == CH_WIDTH'(c))) begin
          if (w_done) begin
            r_min[c] <= MIN_INIT;
            r_max[c] <= '0;
          end else begin
            r_min[c] <= w_min_new;
            r_max[c] <= w_max_new;
          end
        end
      end
    end
  end

  assign out_min = r_out_min_p1;
  assign out_max = r_out_max_p1;

`else

  assign out_min = '0;
  assign out_max = '0;

`endif

endmodule
